// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling around mid-bit.
module uart_rx_fifo #(
    parameter int unsigned UART_CLK_DIV = 434,
    parameter int unsigned FIFO_ASIZE   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rx,
    input  logic       rreq,
    output logic       rgnt,
    output logic [7:0] rdata,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned CycW  = $clog2(UART_CLK_DIV);
    localparam int unsigned Depth = 2 ** FIFO_ASIZE;
    localparam int unsigned Half  = UART_CLK_DIV / 2;
    localparam logic [CycW-1:0] CycLast = CycW'(UART_CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic                  sync1_q, sync2_q, prev_q;
    logic [1:0]            fill_q;
    logic                  armed_q;
    logic                  fall;
    logic                  bit_val;
    logic                  is_dec;
    state_e                state_q, state_d;
    logic [CycW-1:0]       cyc_q, cyc_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  push;
    logic [FIFO_ASIZE-1:0] wr_q, rd_q;
    logic                  overflow_q;
    logic                  empty, full;
    logic [7:0]            mem [Depth];

    // armed_q waits until the synchronizer holds a real post-reset high, so a line
    // held low through reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= i_uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign fall = armed_q & prev_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CycW-1:0] CycEarly = CycW'(Half - 1);
    localparam logic [CycW-1:0] CycMid   = CycW'(Half);
    localparam logic [CycW-1:0] CycDec   = CycW'(Half + 1);

    logic early_q, mid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else begin
            if (cyc_q == CycEarly) early_q <= sync2_q;
            if (cyc_q == CycMid)   mid_q   <= sync2_q;
        end
    end

    assign bit_val = (early_q & mid_q) | (early_q & sync2_q) | (mid_q & sync2_q);
`else
    localparam logic [CycW-1:0] CycDec = CycW'(Half);

    assign bit_val = sync2_q;
`endif

    assign is_dec = (cyc_q == CycDec);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                cyc_d = cyc_q + CycW'(1);
                if (is_dec && bit_val) begin
                    state_d = StIdle;
                    cyc_d   = '0;
                end else if (cyc_q == CycLast) begin
                    state_d = StData;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            StData: begin
                cyc_d = cyc_q + CycW'(1);
                if (is_dec) shift_d = {bit_val, shift_q[7:1]};
                if (cyc_q == CycLast) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                cyc_d = cyc_q + CycW'(1);
                // Leave mid-stop so a following start bit is caught without delay.
                if (is_dec) begin
                    state_d   = StIdle;
                    cyc_d     = '0;
                    push      = bit_val;
                    frame_err = ~bit_val;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty    = (wr_q == rd_q);
    assign full     = ((wr_q + FIFO_ASIZE'(1)) == rd_q);
    assign rgnt     = rreq & ~empty;
    assign rdata    = empty ? 8'h00 : mem[rd_q];
    assign overflow = overflow_q;

    // Fullness is judged before any same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                if (full) overflow_q <= 1'b1;
                else      wr_q       <= wr_q + FIFO_ASIZE'(1);
            end
            if (rgnt) rd_q <= rd_q + FIFO_ASIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !full) begin
            mem[wr_q] <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a frame-level queue model.
// Honours UART_RX_MAJORITY_EN for decision timing and spike expectations.
module tb_uart_rx_fifo;

    localparam int DIV   = 16;
    localparam int ASIZE = 2;
    localparam int CAP   = 3;
    localparam int HALF  = DIV / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC = HALF + 1;
`else
    localparam int DEC = HALF;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rreq = 1'b0;
    logic       rgnt;
    logic [7:0] rdata;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .UART_CLK_DIV(DIV),
        .FIFO_ASIZE  (ASIZE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_uart_rx(rx),
        .rreq     (rreq),
        .rgnt     (rgnt),
        .rdata    (rdata),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ok;
    } frame_t;

    int         cycle = 0;
    int         checks = 0;
    int         failures = 0;
    int         fe_seen = 0;
    int         rreq_mode = 0;
    bit         chk_en = 1'b0;
    bit         model_ovf = 1'b0;
    frame_t     sched[$];
    logic [7:0] mq[$];
    logic [7:0] log_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cycle, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rreq_mode)
                0:       rreq = 1'b0;
                1:       rreq = 1'b1;
                default: rreq = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Model: FIFO contents as a queue; frames resolve at their computed decision cycle.
    initial begin : cmp
        bit     g, dec_now, fe_exp, was_full;
        frame_t f;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                g       = rreq && (mq.size() > 0);
                dec_now = 1'b0;
                if (sched.size() > 0) dec_now = (sched[0].cyc == cycle);
                fe_exp = dec_now && !sched[0].ok;
                check("rgnt", rgnt, g);
                check("rdata", rdata, (mq.size() > 0) ? mq[0] : 8'h00);
                check("frame_err", frame_err, fe_exp);
                check("overflow", overflow, model_ovf);
                if (frame_err) fe_seen++;
                if (rgnt) log_q.push_back(rdata);
                was_full = (mq.size() == CAP);
                if (g) void'(mq.pop_front());
                if (dec_now) begin
                    f = sched.pop_front();
                    if (f.ok) begin
                        if (was_full) model_ovf = 1'b1;
                        else          mq.push_back(f.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sched.delete();
        mq.delete();
        model_ovf = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // spike_bit >= 0 drops the pin low for one clock near mid-bit of that data bit;
    // abort_t >= 0 resets the DUT at that pin cycle and abandons the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int spike_bit,
                              input int abort_t);
        int         e0;
        logic [9:0] bits;
        logic [7:0] exp;
        frame_t     f;
        bits = {stop, data, 1'b0};
        exp  = data;
`ifndef UART_RX_MAJORITY_EN
        if (spike_bit >= 0) exp[spike_bit] = 1'b0;
`endif
        @(posedge clk);
        #1;
        e0     = cycle;
        f.cyc  = e0 + 3 + 9 * DIV + DEC;
        f.data = exp;
        f.ok   = stop;
        sched.push_back(f);
        for (int t = 0; t < 10 * DIV; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (t == abort_t) begin
                rx = 1'b1;
                do_reset();
                return;
            end
            rx = bits[t / DIV];
            if (spike_bit >= 0 && t == 1 + (1 + spike_bit) * DIV + HALF) rx = 1'b0;
        end
        @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic drain();
        rreq_mode = 1;
        for (int i = 0; i < 40 && mq.size() > 0; i++) @(posedge clk);
        wait_cycles(3);
        rreq_mode = 0;
        wait_cycles(2);
    endtask

    task automatic check_log(input string name, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] e[3];
        e = '{b0, b1, b2};
        check({name, "_count"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) check(name, log_q[i], e[i]);
        log_q.delete();
    endtask

    initial begin
        logic [7:0] spike_exp;
        int         gap;
        logic       stop;

        rreq_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rgnt", rgnt, 1'b0);
        check("reset_rdata", rdata, 8'h00);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        rreq_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(5);
        chk_en = 1'b1;
        wait_cycles(4);

        // Two frames buffered, then drained on consecutive grants.
        send_frame(8'h55, 1'b1, -1, -1);
        send_frame(8'hA3, 1'b1, -1, -1);
        wait_cycles(4);
        drain();
        check_log("basic", 2, 8'h55, 8'hA3, 8'h00);

        // Short low glitch on idle line.
        fe_seen = 0;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(3 * DIV);
        check("glitch_fe", fe_seen, 0);
        drain();
        check_log("glitch", 0, 8'h00, 8'h00, 8'h00);

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, -1, -1);
        wait_cycles(8);
        check("stop_err_fe", fe_seen, 1);
        send_frame(8'h7E, 1'b1, -1, -1);
        drain();
        check_log("after_err", 1, 8'h7E, 8'h00, 8'h00);

        // Reset during data bit 3, then a full frame.
        send_frame(8'hC5, 1'b1, -1, 4 * DIV + 8);
        wait_cycles(2 * DIV);
        send_frame(8'hC5, 1'b1, -1, -1);
        drain();
        check_log("mid_reset", 1, 8'hC5, 8'h00, 8'h00);

        // Line held low across reset release must not start a frame.
        rx = 1'b0;
        do_reset();
        wait_cycles(3 * DIV);
        rx = 1'b1;
        wait_cycles(2 * DIV);
        drain();
        check_log("low_reset", 0, 8'h00, 8'h00, 8'h00);

        // One-clock low spike at mid-bit of data bit 2.
`ifdef UART_RX_MAJORITY_EN
        spike_exp = 8'hFF;
`else
        spike_exp = 8'hFB;
`endif
        send_frame(8'hFF, 1'b1, 2, -1);
        drain();
        check_log("spike", 1, spike_exp, 8'h00, 8'h00);

        // Random frames with random consumer.
        rreq_mode = 2;
        for (int i = 0; i < 20; i++) begin
            stop = ($urandom_range(0, 5) != 0);
            send_frame(8'($urandom), stop, -1, -1);
            gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(4, 3 * DIV);
            if (!stop && gap < 4) gap = 4;
            wait_cycles(gap);
        end
        drain();
        log_q.delete();

        // Overflow with capacity 3.
        rreq_mode = 0;
        do_reset();
        send_frame(8'h01, 1'b1, -1, -1);
        send_frame(8'h02, 1'b1, -1, -1);
        send_frame(8'h03, 1'b1, -1, -1);
        check("ovf_before", overflow, 1'b0);
        send_frame(8'h04, 1'b1, -1, -1);
        wait_cycles(4);
        check("ovf_set", overflow, 1'b1);
        drain();
        check_log("ovf_drain", 3, 8'h01, 8'h02, 8'h03);
        check("ovf_sticky", overflow, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
